// File: rtl/regfile_sb_pkg.sv
// Shared pipeline types for the integer register file and its scoreboard.
package regfile_sb_pkg;
    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    typedef logic [XLEN-1:0] word_t;
    typedef logic [AW-1:0]   reg_idx_t;
endpackage

// File: rtl/regfile_sb_bypass.sv
// One read port: storage value overridden by the highest-index accepted write to
// the same address this cycle; register 0 always reads zero.
module regfile_sb_bypass
    import regfile_sb_pkg::*;
#(
    parameter int XLEN = regfile_sb_pkg::XLEN,
    parameter int AW   = regfile_sb_pkg::AW,
    parameter int NWR  = 2
) (
    input  logic [NWR-1:0]           wr_acc,
    input  logic [NWR-1:0][AW-1:0]   wr_addr,
    input  logic [NWR-1:0][XLEN-1:0] wr_data,
    input  logic [AW-1:0]            rd_addr,
    input  logic [XLEN-1:0]          stored,
    output logic [XLEN-1:0]          rd_data
);
    always_comb begin
        rd_data = stored;
        for (int i = 0; i < NWR; i++) begin
            if (wr_acc[i] && wr_addr[i] == rd_addr) rd_data = wr_data[i];
        end
        if (rd_addr == '0) rd_data = '0;
    end
endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write bypass, per-port commit guard and a
// pending-write scoreboard for read-after-write stalls.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter  int XLEN = regfile_sb_pkg::XLEN,
    parameter  int NREG = regfile_sb_pkg::NREG,
    parameter  int NRD  = 2,
    parameter  int NWR  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NRD-1:0][AW-1:0]    rd_addr,
    output logic [NRD-1:0][XLEN-1:0]  rd_data,
    output logic [NRD-1:0]            rd_busy,
    input  logic                      iss_valid,
    input  logic [AW-1:0]             iss_rd,
    input  logic [NWR-1:0]            wr_en,
    input  logic [NWR-1:0][AW-1:0]    wr_addr,
    input  logic [NWR-1:0][XLEN-1:0]  wr_data,
    input  logic [NWR-1:0]            wr_adv,
    output logic [NWR-1:0]            wr_done,
    output logic                      stall,
    output logic [NREG-1:0][XLEN-1:0] regs
);
    logic [NWR-1:0]  done, acc;
    logic [NREG-1:0] busy, clr, set;

    // wr_adv re-arms the guard in the same cycle; reset masks acceptance so
    // nothing bypasses onto rd_data while reset is held
    always_comb begin
        acc = wr_en & (~done | wr_adv) & {NWR{reset_n}};
        clr = '0;
        for (int i = 0; i < NWR; i++) begin
            if (acc[i]) clr[wr_addr[i]] = 1'b1;
        end
        set = '0;
        if (iss_valid && iss_rd != '0) set[iss_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done <= '0;
            busy <= '0;
        end else begin
            done <= acc | (done & ~wr_adv);
            busy <= set | (busy & ~clr);
        end
    end

    assign wr_done = done;
    assign regs[0] = '0;

    for (genvar r = 1; r < NREG; r++) begin : g_reg
        logic [XLEN-1:0] q, nxt;

        always_comb begin
            nxt = q;
            for (int i = 0; i < NWR; i++) begin
                if (acc[i] && wr_addr[i] == AW'(r)) nxt = wr_data[i];
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) q <= '0;
            else          q <= nxt;
        end

        assign regs[r] = q;
    end

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        regfile_sb_bypass #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_byp (
            .wr_acc  (acc),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .rd_addr (rd_addr[j]),
            .stored  (regs[rd_addr[j]]),
            .rd_data (rd_data[j])
        );
        assign rd_busy[j] = busy[rd_addr[j]] & ~clr[rd_addr[j]];
    end

    assign stall = |rd_busy;
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus a randomized run
// against a behavioural model of storage, scoreboard and commit guard.
module tb_regfile_sb;
    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                      clk = 1'b0;
    logic                      reset_n = 1'b0;
    logic [NRD-1:0][AW-1:0]    rd_addr;
    logic [NRD-1:0][XLEN-1:0]  rd_data;
    logic [NRD-1:0]            rd_busy;
    logic                      iss_valid;
    logic [AW-1:0]             iss_rd;
    logic [NWR-1:0]            wr_en;
    logic [NWR-1:0][AW-1:0]    wr_addr;
    logic [NWR-1:0][XLEN-1:0]  wr_data;
    logic [NWR-1:0]            wr_adv;
    logic [NWR-1:0]            wr_done;
    logic                      stall;
    logic [NREG-1:0][XLEN-1:0] regs;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
        .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .iss_valid(iss_valid), .iss_rd(iss_rd), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_adv(wr_adv), .wr_done(wr_done),
        .stall(stall), .regs(regs)
    );

    // reference model state
    logic [XLEN-1:0] m_mem [NREG];
    logic            m_busy[NREG];
    logic [NWR-1:0]  m_done;
    logic [NRD-1:0][XLEN-1:0] e_rd;
    logic [NRD-1:0]           e_busy;
    logic                     e_stall;
    int n_cmp = 0;
    int n_err = 0;

    task automatic m_reset();
        for (int r = 0; r < NREG; r++) begin
            m_mem[r]  = '0;
            m_busy[r] = 1'b0;
        end
        m_done = '0;
    endtask

    function automatic bit m_acc(int i);
        return wr_en[i] && (!m_done[i] || wr_adv[i]);
    endfunction

    // expected combinational outputs for the current inputs
    task automatic m_eval();
        for (int j = 0; j < NRD; j++) begin
            int a;
            logic bz;
            a = int'(rd_addr[j]);
            e_rd[j] = m_mem[a];
            bz = m_busy[a];
            for (int i = 0; i < NWR; i++) begin
                if (m_acc(i) && int'(wr_addr[i]) == a) begin
                    e_rd[j] = wr_data[i];
                    bz = 1'b0;
                end
            end
            if (a == 0) begin
                e_rd[j] = '0;
                bz = 1'b0;
            end
            e_busy[j] = bz;
        end
        e_stall = |e_busy;
    endtask

    task automatic tick();
        logic [NWR-1:0] acc;
        @(posedge clk);
        if (reset_n) begin
            for (int i = 0; i < NWR; i++) acc[i] = m_acc(i);
            for (int i = 0; i < NWR; i++) begin
                if (acc[i]) begin
                    if (wr_addr[i] != 0) m_mem[wr_addr[i]] = wr_data[i];
                    m_busy[wr_addr[i]] = 1'b0;
                end
            end
            for (int i = 0; i < NWR; i++) m_done[i] = acc[i] | (m_done[i] & ~wr_adv[i]);
            if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        rd_addr = '0; iss_valid = 1'b0; iss_rd = '0;
        wr_en = '0; wr_addr = '0; wr_data = '0; wr_adv = '0;
    endtask

    task automatic rearm();
        idle();
        wr_adv = '1;
        tick();
        wr_adv = '0;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        m_reset();
        #2;
        n_cmp++;
        if (regs !== '0 || stall !== 1'b0 || wr_done !== '0 || rd_data !== '0) begin
            n_err++;
            $display("FAIL reset_init: regs0=%h stall=%b done=%b rd=%h required all zero",
                     regs[0], stall, wr_done, rd_data);
        end
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        rearm();
        wr_en = 2'b01; wr_addr[0] = 5; wr_data[0] = 64'h1234;
        iss_valid = 1'b1; iss_rd = 6;
        tick();
        idle();
        rd_addr[0] = 5; rd_addr[1] = 6;
        #1;
        n_cmp++;
        if (regs[5] !== 64'h1234 || stall !== 1'b1) begin
            n_err++;
            $display("FAIL reset_pre: x5=%h stall=%b required 1234/1", regs[5], stall);
        end
        #1 reset_n = 1'b0;
        m_reset();
        #1;
        n_cmp++;
        if (regs !== '0 || rd_data !== '0 || stall !== 1'b0 || wr_done !== '0) begin
            n_err++;
            $display("FAIL reset_mid: x5=%h rd0=%h stall=%b done=%b required zero",
                     regs[5], rd_data[0], stall, wr_done);
        end
        #2 reset_n = 1'b1;
        tick();
        n_cmp++;
        if (regs[5] !== '0 || stall !== 1'b0) begin
            n_err++;
            $display("FAIL reset_after: x5=%h stall=%b required 0/0", regs[5], stall);
        end
    endtask

    task automatic test_guard();
        rearm();
        wr_en = 2'b01; wr_addr[0] = 3; wr_data[0] = 64'hAA;
        repeat (3) tick();
        n_cmp++;
        if (wr_done[0] !== 1'b1 || regs[3] !== 64'hAA) begin
            n_err++;
            $display("FAIL guard_first: done=%b x3=%h required 1/aa", wr_done[0], regs[3]);
        end
        wr_data[0] = 64'hBB;
        repeat (2) tick();
        n_cmp++;
        if (regs[3] !== 64'hAA || wr_done[0] !== 1'b1) begin
            n_err++;
            $display("FAIL guard_hold: x3=%h done=%b required aa/1", regs[3], wr_done[0]);
        end
        wr_adv = 2'b01; rd_addr[0] = 3;
        #2;
        n_cmp++;
        if (rd_data[0] !== 64'hBB) begin
            n_err++;
            $display("FAIL guard_adv_byp: rd0=%h required bb", rd_data[0]);
        end
        tick();
        wr_adv = '0;
        n_cmp++;
        if (regs[3] !== 64'hBB || wr_done[0] !== 1'b1) begin
            n_err++;
            $display("FAIL guard_rearm: x3=%h done=%b required bb/1", regs[3], wr_done[0]);
        end
        wr_data[0] = 64'hCC;
        tick();
        n_cmp++;
        if (regs[3] !== 64'hBB) begin
            n_err++;
            $display("FAIL guard_once: x3=%h required bb", regs[3]);
        end
    endtask

    task automatic test_bypass();
        rearm();
        wr_en = 2'b10; wr_addr[1] = 7; wr_data[1] = 64'h55;
        tick();
        rearm();
        wr_en = 2'b10; wr_addr[1] = 7; wr_data[1] = 64'hDEADBEEF; rd_addr[1] = 7;
        #2;
        n_cmp++;
        if (rd_data[1] !== 64'hDEADBEEF || regs[7] !== 64'h55) begin
            n_err++;
            $display("FAIL bypass_same: rd1=%h x7=%h required deadbeef/55", rd_data[1], regs[7]);
        end
        tick();
        n_cmp++;
        if (regs[7] !== 64'hDEADBEEF) begin
            n_err++;
            $display("FAIL bypass_store: x7=%h required deadbeef", regs[7]);
        end
    endtask

    task automatic test_priority();
        rearm();
        wr_en = 2'b11; wr_addr[0] = 9; wr_data[0] = 64'd1;
        wr_addr[1] = 9; wr_data[1] = 64'd2; rd_addr[0] = 9;
        #2;
        n_cmp++;
        if (rd_data[0] !== 64'd2) begin
            n_err++;
            $display("FAIL prio_byp: rd0=%h required 2", rd_data[0]);
        end
        tick();
        n_cmp++;
        if (regs[9] !== 64'd2 || wr_done !== 2'b11) begin
            n_err++;
            $display("FAIL prio_store: x9=%h done=%b required 2/11", regs[9], wr_done);
        end
    endtask

    task automatic test_scoreboard();
        rearm();
        iss_valid = 1'b1; iss_rd = 4; rd_addr[0] = 4;
        #2;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL sb_issue_cycle: stall=%b required 0", stall);
        end
        tick();
        iss_valid = 1'b0;
        #1;
        n_cmp++;
        if (stall !== 1'b1 || rd_busy[0] !== 1'b1) begin
            n_err++;
            $display("FAIL sb_busy: stall=%b busy0=%b required 1/1", stall, rd_busy[0]);
        end
        wr_en = 2'b01; wr_addr[0] = 4; wr_data[0] = 64'h44;
        #1;
        n_cmp++;
        if (stall !== 1'b0 || rd_data[0] !== 64'h44) begin
            n_err++;
            $display("FAIL sb_unstall: stall=%b rd0=%h required 0/44", stall, rd_data[0]);
        end
        tick();
        rearm();
        iss_valid = 1'b1; iss_rd = 4; wr_en = 2'b01; wr_addr[0] = 4; wr_data[0] = 64'h45;
        tick();
        idle();
        rd_addr[0] = 4;
        #1;
        n_cmp++;
        if (rd_busy[0] !== 1'b1 || regs[4] !== 64'h45) begin
            n_err++;
            $display("FAIL sb_set_wins: busy0=%b x4=%h required 1/45", rd_busy[0], regs[4]);
        end
        rearm();
        wr_en = 2'b01; wr_addr[0] = 4; wr_data[0] = 64'h46;
        tick();
        idle();
    endtask

    task automatic test_x0();
        rearm();
        wr_en = 2'b01; wr_addr[0] = 0; wr_data[0] = 64'hFFFF;
        iss_valid = 1'b1; iss_rd = 0; rd_addr = '0;
        #2;
        n_cmp++;
        if (rd_data[0] !== '0) begin
            n_err++;
            $display("FAIL x0_byp: rd0=%h required 0", rd_data[0]);
        end
        tick();
        n_cmp++;
        if (regs[0] !== '0 || rd_data[0] !== '0 || stall !== 1'b0 || wr_done[0] !== 1'b1) begin
            n_err++;
            $display("FAIL x0: x0=%h rd0=%h stall=%b done=%b required 0/0/0/1",
                     regs[0], rd_data[0], stall, wr_done[0]);
        end
        idle();
    endtask

    task automatic test_random();
        int bad;
        for (int n = 0; n < 400; n++) begin
            for (int j = 0; j < NRD; j++) rd_addr[j] = AW'($urandom_range(0, 7));
            for (int i = 0; i < NWR; i++) begin
                wr_addr[i] = AW'($urandom_range(0, 7));
                wr_data[i] = {$urandom, $urandom};
            end
            wr_en = NWR'($urandom);
            wr_adv = NWR'($urandom) & NWR'($urandom);
            iss_valid = ($urandom_range(0, 2) == 0);
            iss_rd = AW'($urandom_range(0, 7));
            #2;
            m_eval();
            n_cmp++;
            if (rd_data !== e_rd || rd_busy !== e_busy || stall !== e_stall) begin
                n_err++;
                $display("FAIL rnd_read[%0d]: rd=%h busy=%b stall=%b required rd=%h busy=%b stall=%b",
                         n, rd_data, rd_busy, stall, e_rd, e_busy, e_stall);
            end
            n_cmp++;
            if (wr_done !== m_done) begin
                n_err++;
                $display("FAIL rnd_done[%0d]: %b required %b", n, wr_done, m_done);
            end
            bad = -1;
            for (int r = 0; r < NREG; r++) if (regs[r] !== m_mem[r]) bad = r;
            n_cmp++;
            if (bad >= 0) begin
                n_err++;
                $display("FAIL rnd_regs[%0d]: x%0d=%h required %h", n, bad, regs[bad], m_mem[bad]);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_guard();
        test_bypass();
        test_priority();
        test_scoreboard();
        test_x0();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
